// File: rtl/sc_random_checker_pkg.sv
// Shared definitions for the PRBS receive checker: state encoding,
// sequence width and the feedback taps of the 8-bit generator.
package sc_random_checker_pkg;

    localparam int PRBS_W  = 8;
    localparam int TAP_HI  = 7;
    localparam int TAP_MID = 4;
    localparam int TAP_LO  = 1;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } chk_state_t;

endpackage

// File: rtl/sc_random_next.sv
// Next-value function of the 8-bit PRBS: the new MSB is the XOR of the
// tap bits and the register shifts right. Purely combinational.
module sc_random_next
    import sc_random_checker_pkg::*;
(
    input  logic [PRBS_W-1:0] x,
    output logic [PRBS_W-1:0] y
);

    assign y = {x[TAP_HI] ^ x[TAP_MID] ^ x[TAP_LO], x[PRBS_W-1:1]};

endmodule

// File: rtl/sc_random_checker.sv
// PRBS receive checker: seeds its prediction from the incoming samples,
// declares lock after a run of correct predictions, then flywheels the
// prediction and counts mismatched samples in a saturating counter.
//
// state  | meaning
// -------+--------------------------------------------------------------
// HUNT   | waiting for a non-zero sample to seed the prediction
// VERIFY | checking consecutive predictions; any miss reseeds from data
// LOCKED | prediction free-runs; misses pulse error and are counted
module sc_random_checker
    import sc_random_checker_pkg::*;
#(
    parameter int LOCK_COUNT   = 4,
    parameter int LOSS_COUNT   = 3,
    parameter int ERRCNT_WIDTH = 16
) (
    input  logic                    SC_RANDOM_CLOCK_50,
    input  logic                    SC_RANDOM_RESET_InHigh,
    input  logic [PRBS_W-1:0]       SC_RANDOMCHK_data_InBUS,
    input  logic                    SC_RANDOMCHK_valid_InHigh,
    input  logic                    SC_RANDOMCHK_clear_InHigh,
    output logic                    SC_RANDOMCHK_locked_OutHigh,
    output logic                    SC_RANDOMCHK_error_OutHigh,
    output logic [ERRCNT_WIDTH-1:0] SC_RANDOMCHK_errcount_OutBUS
);

    localparam logic [3:0] LOCK_C = 4'(LOCK_COUNT);
    localparam logic [3:0] LOSS_C = 4'(LOSS_COUNT);

    chk_state_t              state_q, state_d;
    logic [PRBS_W-1:0]       pred_q, pred_d;
    logic [3:0]              match_q, match_d;
    logic [3:0]              miss_q, miss_d;
    logic                    locked_q, locked_d;
    logic                    error_q, error_d;
    logic [ERRCNT_WIDTH-1:0] errcnt_q, errcnt_d;

    logic [PRBS_W-1:0]       sample_next;
    logic [PRBS_W-1:0]       pred_next;
    logic [3:0]              match_inc;
    logic [3:0]              miss_inc;

    // Reseed path follows the data, flywheel path follows the prediction.
    sc_random_next u_next_sample (
        .x (SC_RANDOMCHK_data_InBUS),
        .y (sample_next)
    );

    sc_random_next u_next_pred (
        .x (pred_q),
        .y (pred_next)
    );

    assign match_inc = match_q + 4'd1;
    assign miss_inc  = miss_q + 4'd1;

    // State, prediction, counters and output flops.
    always_ff @(posedge SC_RANDOM_CLOCK_50 or posedge SC_RANDOM_RESET_InHigh) begin
        if (SC_RANDOM_RESET_InHigh) begin
            state_q  <= HUNT;
            pred_q   <= '0;
            match_q  <= '0;
            miss_q   <= '0;
            locked_q <= 1'b0;
            error_q  <= 1'b0;
            errcnt_q <= '0;
        end else begin
            state_q  <= state_d;
            pred_q   <= pred_d;
            match_q  <= match_d;
            miss_q   <= miss_d;
            locked_q <= locked_d;
            error_q  <= error_d;
            errcnt_q <= errcnt_d;
        end
    end

    // Next-state decode; clear overrides any increment on the same edge.
    always_comb begin
        state_d  = state_q;
        pred_d   = pred_q;
        match_d  = match_q;
        miss_d   = miss_q;
        locked_d = locked_q;
        error_d  = 1'b0;
        errcnt_d = errcnt_q;

        if (SC_RANDOMCHK_valid_InHigh) begin
            case (state_q)
                HUNT: begin
                    // zero is a fixed point of the generator and cannot seed
                    if (SC_RANDOMCHK_data_InBUS != '0) begin
                        pred_d  = sample_next;
                        match_d = '0;
                        state_d = VERIFY;
                    end
                end
                VERIFY: begin
                    pred_d = sample_next;
                    if (SC_RANDOMCHK_data_InBUS == pred_q) begin
                        match_d = match_inc;
                        if (match_inc == LOCK_C) begin
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                            miss_d   = '0;
                        end
                    end else begin
                        match_d = '0;
                    end
                end
                LOCKED: begin
                    pred_d = pred_next;
                    if (SC_RANDOMCHK_data_InBUS == pred_q) begin
                        miss_d = '0;
                    end else begin
                        error_d = 1'b1;
                        miss_d  = miss_inc;
                        if (errcnt_q != '1) begin
                            errcnt_d = errcnt_q + ERRCNT_WIDTH'(1);
                        end
                        if (miss_inc == LOSS_C) begin
                            state_d  = HUNT;
                            locked_d = 1'b0;
                        end
                    end
                end
                default: begin
                    state_d  = HUNT;
                    locked_d = 1'b0;
                end
            endcase
        end

        if (SC_RANDOMCHK_clear_InHigh) begin
            errcnt_d = '0;
        end
    end

    assign SC_RANDOMCHK_locked_OutHigh  = locked_q;
    assign SC_RANDOMCHK_error_OutHigh   = error_q;
    assign SC_RANDOMCHK_errcount_OutBUS = errcnt_q;

endmodule
